// File: rtl/dino_input_pkg.sv
// Shared constants for the player input path: default debounce/repeat timing
// and named channel indices for the button bank.
package dino_input_pkg;

  localparam int unsigned DEF_CNT_WIDTH      = 4;
  localparam int unsigned DEF_DEBOUNCE_TICKS = 8;
  localparam int unsigned DEF_REPEAT_DELAY   = 32;
  localparam int unsigned DEF_REPEAT_PERIOD  = 8;

  // Channel indices as wired to the player buttons.
  localparam int unsigned CH_UP   = 0;
  localparam int unsigned CH_DOWN = 1;

  // True when a debounce length can be counted by a counter of the given width
  // without wrapping (the counter only ever reaches ticks-1).
  function automatic bit ticks_fit(input int unsigned ticks, input int unsigned width);
    return (ticks >= 1) && (width < 32) && (ticks < (32'd1 << width));
  endfunction

endpackage

// File: rtl/button_debounce_chan.sv
// One button channel: 2-flop synchroniser, optional polarity inversion,
// tick-gated debounce counter, registered level and single-cycle press/release
// pulses. Auto-repeat on long hold is built only when BUTTON_REPEAT_EN is defined.
module button_debounce_chan
  import dino_input_pkg::*;
#(
  parameter int unsigned CNT_WIDTH      = DEF_CNT_WIDTH,
  parameter int unsigned DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter bit          ACTIVE_LOW     = 1'b0,
  parameter int unsigned REPEAT_DELAY   = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD  = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_en,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_TICKS - 1);

  logic                 s1_q, s2_q;
  logic                 cur;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 level_q;
  logic                 press_q, release_q;
  logic                 accept;
  logic                 rep_fire;

  // Bring the asynchronous pin into the clk domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn_raw;
      s2_q <= s1_q;
    end
  end

  // Internally a pressed button always reads 1.
  assign cur = s2_q ^ ACTIVE_LOW;

  // A differing input is accepted on the tick that completes the debounce window.
  assign accept = (cur != level_q) && tick_en && (cnt_q == CNT_LAST);

  // Debounce counter: any agreement with the current level restarts the window.
  always_comb begin
    cnt_d = cnt_q;
    if (cur == level_q) begin
      cnt_d = '0;
    end else if (tick_en) begin
      cnt_d = accept ? '0 : cnt_q + 1'b1;
    end
  end

`ifdef BUTTON_REPEAT_EN
  localparam int unsigned REP_WIDTH = $clog2(REPEAT_DELAY + 1);
  localparam logic [REP_WIDTH-1:0] REP_LAST  = REP_WIDTH'(REPEAT_DELAY - 1);
  localparam logic [REP_WIDTH-1:0] REP_REARM = REP_WIDTH'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [REP_WIDTH-1:0] rep_cnt_q, rep_cnt_d;

  // Repeat never fires on the cycle the level is being released, so press and
  // release stay mutually exclusive.
  assign rep_fire = level_q && tick_en && !accept && (rep_cnt_q == REP_LAST);

  // Count held ticks; after each repeat, restart so the next fires REPEAT_PERIOD later.
  always_comb begin
    rep_cnt_d = rep_cnt_q;
    if (!level_q || accept) begin
      rep_cnt_d = '0;
    end else if (tick_en) begin
      rep_cnt_d = rep_fire ? REP_REARM : rep_cnt_q + 1'b1;
    end
  end

  // Repeat counter state.
  always_ff @(posedge clk) begin
    if (reset) begin
      rep_cnt_q <= '0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign rep_fire          = 1'b0;
`endif

  // Debounce state, stable level and registered edge pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      level_q   <= accept ? cur : level_q;
      press_q   <= (accept && cur) || rep_fire;
      release_q <= accept && !cur;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule

// File: rtl/button_debounce_bank.sv
// N-channel button conditioner: replicates button_debounce_chan per channel
// and rejects illegal timing configurations at elaboration.
// Optional auto-repeat: define BUTTON_REPEAT_EN.
module button_debounce_bank
  import dino_input_pkg::*;
#(
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned CNT_WIDTH      = DEF_CNT_WIDTH,
  parameter int unsigned DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter bit          ACTIVE_LOW     = 1'b0,
  parameter int unsigned REPEAT_DELAY   = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD  = DEF_REPEAT_PERIOD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_en,
  input  logic [NUM_CH-1:0] btn_raw,
  output logic [NUM_CH-1:0] btn_level,
  output logic [NUM_CH-1:0] btn_press,
  output logic [NUM_CH-1:0] btn_release
);

  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("button_debounce_bank: NUM_CH must be at least 1");
  end

  if (!ticks_fit(DEBOUNCE_TICKS, CNT_WIDTH)) begin : g_bad_ticks
    $error("button_debounce_bank: DEBOUNCE_TICKS must be in 1..2^CNT_WIDTH-1");
  end

`ifdef BUTTON_REPEAT_EN
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_rep
    $error("button_debounce_bank: need 1 <= REPEAT_PERIOD <= REPEAT_DELAY");
  end
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    button_debounce_chan #(
      .CNT_WIDTH      (CNT_WIDTH),
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .ACTIVE_LOW     (ACTIVE_LOW),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .tick_en     (tick_en),
      .btn_raw     (btn_raw[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i])
    );
  end

endmodule

// File: tb/tb_button_debounce_bank.sv
// Directed bench for button_debounce_bank: NUM_CH=2, DEBOUNCE_TICKS=4.
// With BUTTON_REPEAT_EN defined it also checks auto-repeat (delay 8, period 3).
module tb_button_debounce_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_en;
  logic [1:0] btn_raw;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic [1:0] btn_release;

  int n_checks = 0;
  int n_bad    = 0;

  button_debounce_bank #(
    .NUM_CH         (2),
    .CNT_WIDTH      (4),
    .DEBOUNCE_TICKS (4),
    .ACTIVE_LOW     (1'b0),
    .REPEAT_DELAY   (8),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tick_en     (tick_en),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [1:0] lvl, input logic [1:0] prs,
                           input logic [1:0] rel);
    check_eq({tag, ".level"},   {30'd0, btn_level},   {30'd0, lvl});
    check_eq({tag, ".press"},   {30'd0, btn_press},   {30'd0, prs});
    check_eq({tag, ".release"}, {30'd0, btn_release}, {30'd0, rel});
  endtask

  initial begin
    reset   = 1'b1;
    tick_en = 1'b1;
    btn_raw = 2'b11;

    // Reset held 3 cycles with both pins high: outputs stay quiet.
    for (int c = 0; c < 3; c++) begin
      step();
      check_out("reset_hold", 2'b00, 2'b00, 2'b00);
    end
    reset = 1'b0;
    // Acceptance lands on the 6th edge after release of reset.
    for (int c = 1; c <= 5; c++) begin
      step();
      check_out("post_reset_wait", 2'b00, 2'b00, 2'b00);
    end
    step();
    check_out("post_reset_accept", 2'b11, 2'b11, 2'b00);
    step();
    check_out("post_reset_pulse_end", 2'b11, 2'b00, 2'b00);

    // Simultaneous release on both channels.
    btn_raw = 2'b00;
    for (int c = 1; c <= 5; c++) begin
      step();
      check_out("rel_wait", 2'b11, 2'b00, 2'b00);
    end
    step();
    check_out("rel_both", 2'b00, 2'b00, 2'b11);
    step();
    check_out("rel_pulse_end", 2'b00, 2'b00, 2'b00);

    // Clean press on channel 0; channel 1 untouched.
    btn_raw = 2'b01;
    for (int c = 1; c <= 5; c++) begin
      step();
      check_out("press_wait", 2'b00, 2'b00, 2'b00);
    end
    step();
    check_out("press_ch0", 2'b01, 2'b01, 2'b00);
    step();
    check_out("press_pulse_end", 2'b01, 2'b00, 2'b00);

    // Glitch on channel 1: 3 cycles high is shorter than the 4-tick window.
    btn_raw = 2'b11;
    for (int c = 1; c <= 3; c++) step();
    btn_raw = 2'b01;
    for (int c = 1; c <= 8; c++) begin
      step();
      check_out("glitch_ch1", 2'b01, 2'b00, 2'b00);
    end

    // Drop channel 0 again before the tick-gating test.
    btn_raw = 2'b00;
    for (int c = 1; c <= 7; c++) step();
    check_out("idle_before_gate", 2'b00, 2'b00, 2'b00);

    // tick_en only every 4th cycle: ticks on edges 4,8,12,16, accept on the 16th.
    btn_raw = 2'b01;
    for (int c = 1; c <= 17; c++) begin
      tick_en = (c % 4 == 0);
      step();
      if (c < 16)       check_out("gate_wait", 2'b00, 2'b00, 2'b00);
      else if (c == 16) check_out("gate_accept", 2'b01, 2'b01, 2'b00);
      else              check_out("gate_after", 2'b01, 2'b00, 2'b00);
    end
    tick_en = 1'b1;

    // Release ch0, then reset while the press count is at 2.
    btn_raw = 2'b00;
    for (int c = 1; c <= 7; c++) step();
    btn_raw = 2'b01;
    for (int c = 1; c <= 4; c++) step();
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      check_out("midcount_reset", 2'b00, 2'b00, 2'b00);
    end
    btn_raw = 2'b00;
    reset   = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      step();
      check_out("midcount_after", 2'b00, 2'b00, 2'b00);
    end

`ifdef BUTTON_REPEAT_EN
    // Hold ch0: press at edge 6, repeats at 14,17,20,23; release driven after 24.
    btn_raw = 2'b01;
    for (int c = 1; c <= 24; c++) begin
      logic [1:0] lv, pr;
      step();
      lv = (c >= 6) ? 2'b01 : 2'b00;
      pr = (c == 6 || c == 14 || c == 17 || c == 20 || c == 23) ? 2'b01 : 2'b00;
      check_out("repeat_hold", lv, pr, 2'b00);
    end
    btn_raw = 2'b00;
    for (int c = 25; c <= 40; c++) begin
      logic [1:0] lv, pr, rl;
      step();
      lv = (c < 30) ? 2'b01 : 2'b00;
      pr = (c == 26 || c == 29) ? 2'b01 : 2'b00;
      rl = (c == 30) ? 2'b01 : 2'b00;
      check_out("repeat_release", lv, pr, rl);
    end
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  // Press and release must never coincide on a channel.
  always @(negedge clk) begin
    if (!reset && (btn_press & btn_release) != 2'b00) begin
      check_eq("press_release_overlap", {30'd0, btn_press & btn_release}, 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
